// File: rtl/cavlc_coeff_pingpong_buf.sv
// Two-bank 4x4 coefficient ping-pong buffer feeding a CAVLC encoder in zigzag order.
// Define CAVLC_BUF_STATS_EN to register per-block total_coeff / trailing_ones alongside each bank.
module cavlc_coeff_pingpong_buf #(
    parameter int COEFF_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [16*COEFF_W-1:0]  in_coeff_i,
    input  logic                   scan_rev_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [COEFF_W-1:0]     out_coeff_o,
    output logic [3:0]             out_idx_o,
    output logic                   out_last_o,
    output logic [4:0]             out_total_coeff_o,
    output logic [1:0]             out_trailing_ones_o
);

    function automatic logic [3:0] zz_addr(input logic [3:0] pos);
        case (pos)
            4'd0:    zz_addr = 4'd0;
            4'd1:    zz_addr = 4'd1;
            4'd2:    zz_addr = 4'd4;
            4'd3:    zz_addr = 4'd8;
            4'd4:    zz_addr = 4'd5;
            4'd5:    zz_addr = 4'd2;
            4'd6:    zz_addr = 4'd3;
            4'd7:    zz_addr = 4'd6;
            4'd8:    zz_addr = 4'd9;
            4'd9:    zz_addr = 4'd12;
            4'd10:   zz_addr = 4'd13;
            4'd11:   zz_addr = 4'd10;
            4'd12:   zz_addr = 4'd7;
            4'd13:   zz_addr = 4'd11;
            4'd14:   zz_addr = 4'd14;
            default: zz_addr = 4'd15;
        endcase
    endfunction

    logic [COEFF_W-1:0] mem_q [2][16];
    logic [1:0]         full_q, full_d;
    logic [1:0]         rev_q;
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [3:0]         idx_q, idx_d;

    logic               wr_en;
    logic               rd_en;
    logic [3:0]         scan_pos;
    logic [3:0]         rd_addr;

    assign in_ready_o  = ~full_q[wr_ptr_q];
    assign out_valid_o = full_q[rd_ptr_q];
    assign wr_en       = in_valid_i & in_ready_o;
    assign rd_en       = out_valid_o & out_ready_i;

    assign scan_pos    = rev_q[rd_ptr_q] ? (4'd15 - idx_q) : idx_q;
    assign rd_addr     = zz_addr(scan_pos);
    assign out_coeff_o = out_valid_o ? mem_q[rd_ptr_q][rd_addr] : '0;
    assign out_idx_o   = idx_q;
    assign out_last_o  = out_valid_o & (idx_q == 4'd15);

    // A write can only target an empty bank and a free only a full one, so both
    // updates to full_d never collide on the same bit.
    always_comb begin
        full_d   = full_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        idx_d    = idx_q;
        if (wr_en) begin
            full_d[wr_ptr_q] = 1'b1;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (rd_en) begin
            if (idx_q == 4'd15) begin
                idx_d            = '0;
                full_d[rd_ptr_q] = 1'b0;
                rd_ptr_d         = ~rd_ptr_q;
            end else begin
                idx_d = idx_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q   <= '0;
            rev_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            idx_q    <= '0;
            for (int unsigned b = 0; b < 2; b++) begin
                for (int unsigned k = 0; k < 16; k++) begin
                    mem_q[b][k] <= '0;
                end
            end
        end else begin
            full_q   <= full_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            idx_q    <= idx_d;
            if (wr_en) begin
                rev_q[wr_ptr_q] <= scan_rev_i;
                for (int unsigned k = 0; k < 16; k++) begin
                    mem_q[wr_ptr_q][k] <= in_coeff_i[k*COEFF_W +: COEFF_W];
                end
            end
        end
    end

`ifdef CAVLC_BUF_STATS_EN
    localparam logic [COEFF_W-1:0] ONE = {{(COEFF_W-1){1'b0}}, 1'b1};

    logic [4:0]         tc_q [2];
    logic [1:0]         t1_q [2];
    logic [4:0]         wr_tc;
    logic [1:0]         wr_t1;
    logic               t1_stop;
    logic [COEFF_W-1:0] stat_v;

    // Trailing ones always walk from (3,3) back toward (0,0), regardless of scan_rev.
    always_comb begin
        wr_tc   = '0;
        wr_t1   = '0;
        t1_stop = 1'b0;
        stat_v  = '0;
        for (int unsigned k = 0; k < 16; k++) begin
            if (in_coeff_i[k*COEFF_W +: COEFF_W] != '0) begin
                wr_tc = wr_tc + 5'd1;
            end
        end
        for (int unsigned k = 0; k < 16; k++) begin
            stat_v = in_coeff_i[zz_addr(4'(15 - k))*COEFF_W +: COEFF_W];
            if (!t1_stop && (stat_v != '0)) begin
                if ((stat_v == ONE) || (stat_v == '1)) begin
                    if (wr_t1 != 2'd3) begin
                        wr_t1 = wr_t1 + 2'd1;
                    end
                end else begin
                    t1_stop = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tc_q[0] <= '0;
            tc_q[1] <= '0;
            t1_q[0] <= '0;
            t1_q[1] <= '0;
        end else if (wr_en) begin
            tc_q[wr_ptr_q] <= wr_tc;
            t1_q[wr_ptr_q] <= wr_t1;
        end
    end

    assign out_total_coeff_o   = out_valid_o ? tc_q[rd_ptr_q] : '0;
    assign out_trailing_ones_o = out_valid_o ? t1_q[rd_ptr_q] : '0;
`else
    assign out_total_coeff_o   = '0;
    assign out_trailing_ones_o = '0;
`endif

endmodule
